// File: rtl/tx_phyretrain.sv
// Purpose: initiator side of the PHYRETRAIN sideband handshake; sends START_REQ, waits for START_RESP.
// Latency: enable to o_valid_tx = 2 cycles (uncontended); START_RESP sample to o_phyretrain_end_tx = 2 cycles.
// Backpressure: request raise is held off while i_SB_Busy or i_rx_valid is high; i_falling_edge_busy drops valid.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_phyretrain_en          LTSM enable; low returns the block to IDLE
//   i_retrain_cause[2:0]     [0] TXSELFCAL, [1] SPEEDIDLE, [2] REPAIR
//   i_SB_Busy                sideband busy
//   i_falling_edge_busy      sideband finished consuming the current message
//   i_rx_valid               receive-side block is driving the wrapper
//   i_rx_msg_valid           decoded sideband message valid
//   i_decoded_SB_msg         decoded partner message ID
//   o_encoded_SB_msg_tx      message ID to send (1 = START_REQ)
//   o_retrain_encoding_tx    latched one-hot encoding: 001 TXSELFCAL, 010 SPEEDIDLE, 100 REPAIR
//   o_valid_tx               wrapper valid
//   o_phyretrain_end_tx      handshake done (level)
//   o_timeout                partner did not respond (level)
module tx_phyretrain #(
   parameter int unsigned          SB_MSG_WIDTH   = 4,
   parameter int unsigned          TIMEOUT_W      = 20,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'd800000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_phyretrain_en,
   input  logic [2:0]              i_retrain_cause,
   input  logic                    i_SB_Busy,
   input  logic                    i_falling_edge_busy,
   input  logic                    i_rx_valid,
   input  logic                    i_rx_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
   output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
   output logic [2:0]              o_retrain_encoding_tx,
   output logic                    o_valid_tx,
   output logic                    o_phyretrain_end_tx,
   output logic                    o_timeout
);

   localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ  = SB_MSG_WIDTH'(1);
   localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP = SB_MSG_WIDTH'(2);
   localparam logic [TIMEOUT_W-1:0]    CNT_LAST       = TIMEOUT_CYCLES - TIMEOUT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE                = 3'd0,
      ST_SEND_START_REQ      = 3'd1,
      ST_WAIT_FOR_START_RESP = 3'd2,
      ST_TEST_FINISHED       = 3'd3,
      ST_TIMEOUT             = 3'd4
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   logic                   started_q;     // entry actions already performed this handshake
   logic                   req_pending_q; // request deferred by contention
   logic                   resp_seen_q;   // START_RESP seen (possibly before WAIT)
   logic                   valid_prev_q;
   logic                   fall_det_q;    // registered falling edge of o_valid_tx
   logic [TIMEOUT_W-1:0]   cnt_q;

   logic                   active;
   logic                   entry;
   logic                   resp_now;
   logic                   path_clear;
   logic                   raise;
   logic                   cnt_last;
   logic [2:0]             prio_enc;

   assign active     = (state_q == ST_SEND_START_REQ) || (state_q == ST_WAIT_FOR_START_RESP);
   // Entry actions fire in the first SEND cycle, so they see the cause sampled there.
   assign entry      = (state_q == ST_SEND_START_REQ) && !started_q;
   assign resp_now   = i_rx_msg_valid && (i_decoded_SB_msg == MSG_START_RESP);
   assign path_clear = !i_SB_Busy && !i_rx_valid;
   assign raise      = (entry || req_pending_q) && path_clear;
   assign cnt_last   = (cnt_q == CNT_LAST);

   // SPEEDIDLE outranks REPAIR, which outranks TXSELFCAL; no cause defaults to TXSELFCAL.
   always_comb begin
      prio_enc = 3'b001;
      if (i_retrain_cause[1]) begin
         prio_enc = 3'b010;
      end else if (i_retrain_cause[2]) begin
         prio_enc = 3'b100;
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_phyretrain_en) begin
               state_d = ST_SEND_START_REQ;
            end
         end
         ST_SEND_START_REQ: begin
            if (cnt_last) begin
               state_d = ST_TIMEOUT;
            end else if (fall_det_q) begin
               state_d = ST_WAIT_FOR_START_RESP;
            end
         end
         ST_WAIT_FOR_START_RESP: begin
            // A response on the final count still counts as success.
            if (resp_seen_q || resp_now) begin
               state_d = ST_TEST_FINISHED;
            end else if (cnt_last) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_TEST_FINISHED: begin
            state_d = ST_TEST_FINISHED;
         end
         ST_TIMEOUT: begin
            state_d = ST_TIMEOUT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Dropping enable overrides every other transition.
      if (!i_phyretrain_en) begin
         state_d = ST_IDLE;
      end
   end

   // Registered datapath and outputs; IDLE clears everything like reset does.
   always_ff @(posedge i_clk) begin
      if (i_rst || (state_q == ST_IDLE)) begin
         started_q             <= 1'b0;
         req_pending_q         <= 1'b0;
         resp_seen_q           <= 1'b0;
         valid_prev_q          <= 1'b0;
         fall_det_q            <= 1'b0;
         cnt_q                 <= '0;
         o_encoded_SB_msg_tx   <= '0;
         o_retrain_encoding_tx <= 3'b000;
         o_valid_tx            <= 1'b0;
         o_phyretrain_end_tx   <= 1'b0;
         o_timeout             <= 1'b0;
      end else begin
         valid_prev_q <= o_valid_tx;
         fall_det_q   <= valid_prev_q && !o_valid_tx;

         if (active) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
         end

         if (active && resp_now) begin
            resp_seen_q <= 1'b1;
         end

         if (entry) begin
            started_q             <= 1'b1;
            o_encoded_SB_msg_tx   <= MSG_START_REQ;
            o_retrain_encoding_tx <= prio_enc;
         end

         // Busy falling edge wins over a simultaneous raise.
         if (i_falling_edge_busy) begin
            o_valid_tx <= 1'b0;
         end else if (raise) begin
            o_valid_tx <= 1'b1;
         end

         // Pending survives until valid actually goes high, so an entry raise
         // masked by a coincident busy falling edge is retried next cycle.
         if (raise && !i_falling_edge_busy) begin
            req_pending_q <= 1'b0;
         end else if (entry) begin
            req_pending_q <= 1'b1;
         end

         if (state_q == ST_TEST_FINISHED) begin
            o_phyretrain_end_tx <= 1'b1;
         end

         if (state_q == ST_TIMEOUT) begin
            o_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_phyretrain.sv
// Purpose: randomized scoreboard bench for tx_phyretrain; a timeline model predicts every output change.
// Latency: each expected change carries the exact edge number at which it must appear.
// Backpressure: contention on i_rx_valid / i_SB_Busy is randomized and folded into the predicted raise edge.
module tb_tx_phyretrain;

   localparam int SBW = 4;
   localparam int TC  = 16;

   logic           i_clk = 1'b0;
   logic           i_rst;
   logic           i_phyretrain_en;
   logic [2:0]     i_retrain_cause;
   logic           i_SB_Busy;
   logic           i_falling_edge_busy;
   logic           i_rx_valid;
   logic           i_rx_msg_valid;
   logic [SBW-1:0] i_decoded_SB_msg;
   logic [SBW-1:0] o_encoded_SB_msg_tx;
   logic [2:0]     o_retrain_encoding_tx;
   logic           o_valid_tx;
   logic           o_phyretrain_end_tx;
   logic           o_timeout;

   tx_phyretrain #(
      .SB_MSG_WIDTH  (SBW),
      .TIMEOUT_W     (20),
      .TIMEOUT_CYCLES(20'd16)
   ) dut (
      .i_clk                (i_clk),
      .i_rst                (i_rst),
      .i_phyretrain_en      (i_phyretrain_en),
      .i_retrain_cause      (i_retrain_cause),
      .i_SB_Busy            (i_SB_Busy),
      .i_falling_edge_busy  (i_falling_edge_busy),
      .i_rx_valid           (i_rx_valid),
      .i_rx_msg_valid       (i_rx_msg_valid),
      .i_decoded_SB_msg     (i_decoded_SB_msg),
      .o_encoded_SB_msg_tx  (o_encoded_SB_msg_tx),
      .o_retrain_encoding_tx(o_retrain_encoding_tx),
      .o_valid_tx           (o_valid_tx),
      .o_phyretrain_end_tx  (o_phyretrain_end_tx),
      .o_timeout            (o_timeout)
   );

   initial forever #5 i_clk = ~i_clk;

   // Output vector: {valid, end, timeout, msg[3:0], enc[2:0]}
   typedef struct {
      int         cyc;
      logic [9:0] vec;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc    = 0;
   int         n_cmp  = 0;
   int         n_bad  = 0;
   bit         mon_en = 1'b0;
   logic [9:0] mon_prev;

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // Monitor: every change of the output vector must match the next predicted change.
   initial begin
      logic [9:0] cur;
      exp_t       e;
      forever begin
         @(negedge i_clk);
         if (mon_en) begin
            cur = {o_valid_tx, o_phyretrain_end_tx, o_timeout, o_encoded_SB_msg_tx, o_retrain_encoding_tx};
            if (cur != mon_prev) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL out_change: cyc=%0d got vec=%b, required no change", cyc, cur);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.vec != cur) begin
                     n_bad++;
                     $display("FAIL out_change: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                              cyc, cur, e.cyc, e.vec);
                  end
               end
               mon_prev = cur;
            end
         end
      end
   end

   task automatic check_zero(input string name, input logic [9:0] got);
      n_cmp++;
      if (got != 10'd0) begin
         n_bad++;
         $display("FAIL %s: got %0h, required 0", name, got);
      end
   endtask

   task automatic idle_inputs();
      i_rst               = 1'b0;
      i_phyretrain_en     = 1'b0;
      i_SB_Busy           = 1'b0;
      i_falling_edge_busy = 1'b0;
      i_rx_valid          = 1'b0;
      i_rx_msg_valid      = 1'b0;
      i_decoded_SB_msg    = '0;
   endtask

   // One handshake. Edge numbers are relative to e, the edge after which enable is driven high.
   //   k     : contention (rx_valid or SB_Busy) sampled high on edges e+1..e+k
   //   fd    : busy falling edge sampled fd edges after valid rises
   //   r_rel : START_RESP sampled at edge e+r_rel (negative = never)
   //   mode  : 0 run to completion then drop enable, 1 drop enable in WAIT, 2 reset mid-SEND
   task automatic run_scn(input logic [2:0] cause, input bit cont_busy, input int k,
                          input int fd, input int r_rel, input int mode);
      int         e, v, f, r, lim, ex, tt, d, c, xr;
      bit         term_end;
      logic [2:0] enc;
      logic [9:0] pv, nv;
      logic [3:0] nid;
      exp_t       item;

      e   = cyc;
      v   = (k + 1 > 2) ? e + k + 1 : e + 2;   // valid rises the edge after contention clears
      f   = v + fd;
      r   = (r_rel < 0) ? -1 : e + r_rel;
      lim = e + TC + 1;                          // last edge the machine is still active
      ex  = (r > f + 3) ? r : f + 3;             // WAIT is entered after f+2
      term_end = (r >= 0) && (ex <= lim);
      tt  = term_end ? ex + 1 : lim + 1;
      xr  = v + 1;
      if (mode == 0) begin
         d = tt + 2;
         c = d + 2;
      end else if (mode == 1) begin
         d = f + 3;
         c = d + 2;
      end else begin
         d = xr;
         c = xr + 1;
      end
      enc = cause[1] ? 3'b010 : (cause[2] ? 3'b100 : 3'b001);

      pv = '0;
      for (int t = e + 2; t <= c; t++) begin
         nv = {(t >= v && t < f && t < c),
               (term_end && t >= tt && t < c),
               (!term_end && t >= tt && t < c),
               (t < c) ? 4'd1 : 4'd0,
               (t < c) ? enc : 3'b000};
         if (nv != pv) begin
            item.cyc = t;
            item.vec = nv;
            exp_q.push_back(item);
         end
         pv = nv;
      end

      // Inputs set here are sampled at edge s.
      for (int s = e + 1; s <= c + 1; s++) begin
         i_phyretrain_en     = (s <= d);
         i_retrain_cause     = cause;
         i_rx_valid          = !cont_busy && (s <= e + k);
         i_SB_Busy           = cont_busy && (s <= e + k);
         i_falling_edge_busy = (s == f);
         i_rst               = (mode == 2) && (s == xr + 1);
         if (s == r) begin
            i_rx_msg_valid   = 1'b1;
            i_decoded_SB_msg = 4'd2;
         end else if ($urandom_range(0, 3) == 0) begin
            nid = 4'($urandom_range(0, 15));
            if (nid == 4'd2) nid = 4'd5;
            i_rx_msg_valid   = 1'b1;
            i_decoded_SB_msg = nid;
         end else begin
            i_rx_msg_valid   = 1'b0;
            i_decoded_SB_msg = 4'($urandom_range(0, 15));
         end
         @(posedge i_clk);
         #1;
      end

      idle_inputs();
      repeat (2) begin
         @(posedge i_clk);
         #1;
      end

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_changes: got %0d unseen, required 0 (first cyc=%0d vec=%b)",
                  exp_q.size(), exp_q[0].cyc, exp_q[0].vec);
         exp_q.delete();
      end
   endtask

   initial begin
      idle_inputs();
      i_retrain_cause = 3'b000;
      i_rst           = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check_zero("rst_valid", {9'd0, o_valid_tx});
      check_zero("rst_end",   {9'd0, o_phyretrain_end_tx});
      check_zero("rst_tout",  {9'd0, o_timeout});
      check_zero("rst_msg",   {6'd0, o_encoded_SB_msg_tx});
      check_zero("rst_enc",   {7'd0, o_retrain_encoding_tx});
      i_rst    = 1'b0;
      mon_prev = '0;
      mon_en   = 1'b1;
      @(posedge i_clk);
      #1;

      // Basic handshake: response lands exactly on the final active count.
      run_scn(3'b001, 1'b0, 0, 5, 17, 0);
      run_scn(3'b001, 1'b0, 0, 5, 11, 0);
      // Priority
      run_scn(3'b111, 1'b0, 0, 3, 10, 0);
      run_scn(3'b101, 1'b0, 0, 3, 10, 0);
      run_scn(3'b000, 1'b0, 0, 2, 9, 0);
      // Contention on rx_valid, then on SB_Busy
      run_scn(3'b010, 1'b0, 6, 3, 15, 0);
      run_scn(3'b100, 1'b1, 3, 2, 12, 0);
      // Early response while valid is still high
      run_scn(3'b001, 1'b0, 0, 4, 3, 0);
      // Timeout with no response; response one edge too late
      run_scn(3'b011, 1'b0, 0, 3, -1, 0);
      run_scn(3'b001, 1'b0, 0, 2, 18, 0);
      run_scn(3'b001, 1'b0, 0, 2, 17, 0);
      // Abort in WAIT, then clean restart
      run_scn(3'b110, 1'b0, 0, 3, -1, 1);
      run_scn(3'b001, 1'b0, 0, 3, 10, 0);
      // Reset mid-SEND, then clean restart
      run_scn(3'b101, 1'b0, 0, 8, -1, 2);
      run_scn(3'b010, 1'b1, 2, 3, 8, 0);

      for (int i = 0; i < 40; i++) begin
         int m;
         int rr;
         m  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
         rr = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(2, 22));
         run_scn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), rr, m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
